cen_monitor: RTL
================

# cen_monitor

Measures clock-enable pulse trains such as the 12/6/2 MHz enables derived from the 24 MHz system clock. For each fixed window of `clk` cycles it counts `cen` pulses and records the longest pulse-to-pulse period. It flags whether the count is within limits and whether the enable has stopped. It sits on the consuming side of the enable generator, feeding diagnostics and on-screen timing readouts.

## Interface

Parameters:

- `WINDOW`, default 24000: window length in `clk` cycles (1 ms at 24 MHz); must be ≥ 2.
- `CW`, default 16: width of pulse counter and `count`.
- `EXP_MIN`, default 5999: lowest in-range count.
- `EXP_MAX`, default 6001: highest in-range count.

Ports:

- `clk` in 1: system clock, 24 MHz.
- `rst` in 1: synchronous, active-high reset.
- `cen` in 1: enable pulse train under test, sampled every `clk`.
- `count` out CW: pulses in the last completed window.
- `gap_max` out 8: longest period in `clk` cycles seen in the last window; saturates at 255.
- `in_range` out 1: `EXP_MIN` ≤ `count` ≤ `EXP_MAX`.
- `stuck` out 1: the last window contained zero pulses.
- `valid` out 1: one-cycle strobe marking that the outputs have just been updated.

## Operation

- **State machine:** two states.
  - WARM: entered on reset. The first window is measured but discarded, because the period reference is undefined.
  - WARM → RUN at the end of the first window.
  - RUN stays RUN until `rst`.
- **Window counter `wcnt`:** runs 0..`WINDOW`-1 and wraps to 0. The last cycle is `wcnt`=`WINDOW`-1.
- **Pulse counter `pcnt`:**
  - Increments on `cen` and saturates at 2^CW-1.
  - At window end, the total is `pcnt + cen` (saturated), so a pulse on the last cycle belongs to the ending window.
  - `pcnt` restarts at 0 for the next window.
- **Gap counter `gcnt`** (8 bits, saturating at 255):
  - Cleared to 0 on `cen`; otherwise increments.
  - On `cen`, period = min(`gcnt`+1, 255); consecutive pulses give period 1.
  - The running max `rmax` updates with each period and clears to 0 at window end.
  - A period completed on the last window cycle counts toward the ending window.
  - A period spanning a window boundary counts toward the window in which its closing pulse lands.
- **Window end in RUN** (registered):
  - `count` ← total.
  - `gap_max` ← max(`rmax`, period of this cycle).
  - `in_range` ← range test on total.
  - `stuck` ← (total == 0).
  - `valid` ← 1.
- **Window end in WARM:** internal counters restart as above; outputs are unchanged.
- Outputs hold their values between updates.

## Timing

- **Reset values:** `count`=0, `gap_max`=0, `in_range`=0, `stuck`=0, `valid`=0. Internal state: WARM, `wcnt`=0, `pcnt`=0, `gcnt`=0, `rmax`=0.
- **Cycle numbering:** the first cycle with `rst` low is cycle 0.
  - The WARM window covers cycles 0..`WINDOW`-1.
  - RUN window k (k ≥ 1) covers cycles k·`WINDOW`..(k+1)·`WINDOW`-1.
  - `valid` is high in the single cycle (k+1)·`WINDOW`.
  - Outputs change in that same cycle.
- **Latency:** one cycle from the last window cycle to updated outputs.
- **`valid` period:** exactly one cycle high every `WINDOW` cycles; never high during WARM.
- **`rst` mid-window:**
  - All registers take their reset values in the next cycle.
  - The partial window is discarded.
  - The block re-enters WARM and the numbering restarts.
- **`rst` in the same cycle as a window end:** reset wins; no `valid`.
- `cen` is used as a level each cycle; there is no edge detection.

## Test plan

Use `WINDOW`=24, `CW`=16, `EXP_MIN`=5, `EXP_MAX`=7 unless noted. All cases release `rst` at cycle 0.

1. `cen` high when cycle mod 4 == 0 → no `valid` in cycles 0..47. `valid` at cycle 48 with `count`=6, `gap_max`=4, `in_range`=1, `stuck`=0. The same values repeat at cycles 72, 96, and so on.
2. `cen` held high → at cycle 48, `count`=24, `gap_max`=1, `in_range`=0, `stuck`=0.
3. `cen` held low → at cycle 48, `count`=0, `gap_max`=0, `in_range`=0, `stuck`=1.
4. Single `cen` only on cycles 47 and 71 → at cycle 48, `count`=1 and `gap_max`=255. At cycle 72, `count`=1 and `gap_max`=24, which checks last-cycle inclusion and the boundary-spanning period.
5. Period-4 stream as in case 1, with one pulse at cycle 32 removed → at cycle 48, `count`=5, `gap_max`=8, `in_range`=1.
6. Period-4 stream with `rst` pulsed high at cycle 60 (new cycle 0 = 61) → all outputs read 0 from cycle 61. No `valid` for 48 cycles afterward; the first `valid` is at cycle 109, with `count`=6.

Source files
------------

// File: rtl/cen_monitor.sv
// Clock-enable pulse-train monitor: per fixed window of clk cycles, counts cen
// pulses, tracks the longest pulse-to-pulse period and flags range/stuck status.
module cen_monitor #(
  parameter int WINDOW  = 24000,
  parameter int CW      = 16,
  parameter int EXP_MIN = 5999,
  parameter int EXP_MAX = 6001
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  output logic [CW-1:0] count,
  output logic [7:0]    gap_max,
  output logic          in_range,
  output logic          stuck,
  output logic          valid
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);
  localparam logic [CW-1:0] MINV = CW'(EXP_MIN);
  localparam logic [CW-1:0] MAXV = CW'(EXP_MAX);

  typedef enum logic {WARM, RUN} state_t;
  state_t state_q, state_d;

  logic [WW-1:0] wcnt;
  logic [CW-1:0] pcnt;
  logic [7:0]    gcnt;
  logic [7:0]    rmax;
  logic          seen;

  logic          last;
  logic [CW-1:0] total;
  logic [7:0]    period;
  logic [7:0]    gmax_now;

  always_ff @(posedge clk) begin
    if (rst) state_q <= WARM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    last    = (wcnt == LAST);
    if (state_q == WARM && last) state_d = RUN;

    total = (pcnt == '1) ? pcnt : pcnt + CW'(cen);

    // A pulse with no earlier pulse since reset has no reference: treat as saturated.
    period = '0;
    if (cen) begin
      if (!seen || gcnt == 8'hFF) period = 8'hFF;
      else                        period = gcnt + 8'd1;
    end
    gmax_now = (period > rmax) ? period : rmax;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      pcnt     <= '0;
      gcnt     <= '0;
      rmax     <= '0;
      seen     <= 1'b0;
      count    <= '0;
      gap_max  <= '0;
      in_range <= 1'b0;
      stuck    <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (cen) begin
        gcnt <= '0;
        seen <= 1'b1;
      end else if (gcnt != 8'hFF) begin
        gcnt <= gcnt + 8'd1;
      end

      if (last) begin
        wcnt <= '0;
        pcnt <= '0;
        rmax <= '0;
        if (state_q == RUN) begin
          count    <= total;
          gap_max  <= gmax_now;
          in_range <= (total >= MINV) && (total <= MAXV);
          stuck    <= (total == '0);
          valid    <= 1'b1;
        end
      end else begin
        wcnt <= wcnt + WW'(1);
        pcnt <= total;
        rmax <= gmax_now;
      end
    end
  end

endmodule
